// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// PC arithmetic constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake into a single-entry instruction register, handles branch redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [31:0] fetch_count
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] br_pc;
  logic        deliver;

  assign br_pc   = br_target & WORD_MASK;
  assign deliver = inst_valid_q && !stall && !br_en;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q       <= S_INIT;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      instr_q       <= 32'd0;
      inst_valid_q  <= 1'b0;
      pc_out_q      <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      inst_valid_q  <= inst_valid_d;
      pc_out_q      <= pc_out_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    inst_valid_d  = inst_valid_q;
    pc_out_d      = pc_out_q;
    fetch_count_d = fetch_count_q;

    if (deliver) begin
      inst_valid_d  = 1'b0;
      fetch_count_d = fetch_count_q + 32'd1;
    end
    // A redirect flushes whatever sits in the buffer, delivered or not.
    if (br_en) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_INIT: begin
        mem_req_d = 1'b0;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req_d = 1'b0;
        if (br_en) begin
          pc_d = br_pc;
        end else if (!inst_valid_q || !stall) begin
          mem_addr_d = pc_q;
          mem_req_d  = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req_d = 1'b1;
        if (br_en) begin
          pc_d   = br_pc;
          kill_d = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_ISSUE;
          // A word answering a redirected fetch is stale and dropped.
          if (kill_q || br_en) begin
            kill_d = 1'b0;
          end else begin
            instr_d      = mem_rdata;
            pc_out_d     = pc_q;
            pc_d         = pc_q + PC_STEP;
            inst_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_INIT;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instruction = instr_q;
  assign inst_valid  = inst_valid_q;
  assign pc_out      = pc_out_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// against a program-order scoreboard of expected delivered PCs.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  int          model_cnt = 0;
  int          lat_max   = 0;
  bit          lat_rand  = 1'b0;
  bit          force_ack = 1'b0;

  logic        p_req = 1'b0, p_ack = 1'b0, p_clr = 1'b1;
  logic        p_valid = 1'b0, p_stall = 1'b0, p_br = 1'b0;
  logic [31:0] p_addr = 32'd0, p_inst = 32'd0, p_pc = 32'd0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .br_en      (br_en),
    .br_target  (br_target),
    .stall      (stall),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .pc_out     (pc_out),
    .fetch_count(fetch_count)
  );

  always #5 Clk = ~Clk;

  // Program image held in the instruction memory.
  function automatic logic [31:0] prog_word(input logic [31:0] a);
    if (a == RST_PC) return 32'hE3A0_1005;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected delivery order restarts at a new address on reset or redirect.
  task automatic stream_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic branch_on(input logic [31:0] t);
    br_en     = 1'b1;
    br_target = t;
    stream_restart(t & 32'hFFFF_FFFC);
  endtask

  task automatic wait_sig(input int which, input logic val, input string name);
    logic s;
    s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      s = (which == 0) ? mem_req : inst_valid;
      if (s == val) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout, signal=%0b required=%0b", name, s, val);
  endtask

  // Memory responder: fixed or random latency, optional stray acks.
  initial begin
    int lat;
    bit busy;
    lat  = 0;
    busy = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (!mem_req) begin
        busy = 1'b0;
        if (lat_rand && ($urandom % 8 == 0)) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end else begin
        if (!busy) begin
          busy = 1'b1;
          lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_max;
        end
        if (lat == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = prog_word(mem_addr);
          busy      = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every delivery and checks invariants.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (Clr) begin
        model_cnt = 0;
      end else begin
        chk("fetch_count", fetch_count, 32'(model_cnt));
        if (mem_req) chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        if (!p_clr && p_req && !p_ack) begin
          chk("req_held", {31'd0, mem_req}, 32'd1);
          chk("addr_held", mem_addr, p_addr);
        end
        if (!p_clr && p_valid && p_stall && !p_br) begin
          chk("stall_valid", {31'd0, inst_valid}, 32'd1);
          chk("stall_inst", instruction, p_inst);
          chk("stall_pc", pc_out, p_pc);
        end
        if (inst_valid && !stall && !br_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: delivery pc=%h with no expected entry", pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_pc", pc_out, e);
            chk("deliver_inst", instruction, prog_word(e));
            $display("deliver #%0d pc=%h inst=%h", model_cnt, pc_out, instruction);
            exp_q.push_back(exp_q[$] + 32'd4);
            model_cnt++;
          end
        end
      end
      p_req   = mem_req;
      p_ack   = mem_ack;
      p_clr   = Clr;
      p_valid = inst_valid;
      p_stall = stall;
      p_br    = br_en;
      p_addr  = mem_addr;
      p_inst  = instruction;
      p_pc    = pc_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    stream_restart(RST_PC);
    repeat (2) tick();
    @(negedge Clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, RST_PC);
    chk("rst_inst", instruction, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);

    // Reset release and zero-wait fetch
    tick(); Clr = 1'b0;
    tick();
    @(negedge Clk); chk("init_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    @(negedge Clk);
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    tick();
    @(negedge Clk);
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_inst", instruction, 32'hE3A0_1005);
    chk("first_pc", pc_out, 32'h100);
    tick(); stall = 1'b1;
    @(negedge Clk);
    chk("second_addr", mem_addr, 32'h104);
    chk("second_req", {31'd0, mem_req}, 32'd1);

    // Stall holds the buffer and blocks further requests
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("stall_no_req", {31'd0, mem_req}, 32'd0);
      chk("stall_word", instruction, prog_word(32'h104));
      chk("stall_cnt", fetch_count, 32'd1);
      tick();
    end
    stall = 1'b0; lat_max = 3;
    tick();
    @(negedge Clk);
    chk("release_cnt", fetch_count, 32'd2);
    chk("release_addr", mem_addr, 32'h108);
    $display("stall scenario done");

    // Three wait states
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge Clk);
      chk("ws_req", {31'd0, mem_req}, 32'd1);
      chk("ws_addr", mem_addr, 32'h108);
      chk("ws_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    tick();
    @(negedge Clk);
    chk("ws_capture", instruction, prog_word(32'h108));
    chk("ws_valid", {31'd0, inst_valid}, 32'd1);

    // Branch while a fetch is outstanding
    wait_sig(0, 1'b1, "br_wait_req");
    tick(); branch_on(32'h203);
    tick(); br_en = 1'b0;
    wait_sig(0, 1'b0, "br_wait_ack");
    chk("br_wait_flush", {31'd0, inst_valid}, 32'd0);
    wait_sig(0, 1'b1, "br_wait_reissue");
    chk("br_wait_addr", mem_addr, 32'h200);
    chk("br_wait_still_empty", {31'd0, inst_valid}, 32'd0);
    wait_sig(1, 1'b1, "br_wait_word");
    chk("br_wait_pc", pc_out, 32'h200);
    lat_max = 2;

    // Branch in the same cycle as the ack
    wait_sig(0, 1'b1, "simul_req");
    tick(); tick(); branch_on(32'h300);
    tick(); br_en = 1'b0; lat_max = 0;
    @(negedge Clk); chk("simul_discard", {31'd0, inst_valid}, 32'd0);
    wait_sig(0, 1'b1, "simul_reissue");
    chk("simul_addr", mem_addr, 32'h300);

    // Branch in the same cycle as a delivery
    tick(); stall = 1'b1;
    @(negedge Clk);
    chk("dlv_held", {31'd0, inst_valid}, 32'd1);
    chk("dlv_pc", pc_out, 32'h300);
    tick(); stall = 1'b0; branch_on(32'h400);
    tick(); br_en = 1'b0;
    @(negedge Clk);
    chk("dlv_flushed", {31'd0, inst_valid}, 32'd0);
    chk("dlv_not_counted", fetch_count, 32'd4);

    // PC wrap
    wait_sig(1, 1'b1, "wrap_pre");
    chk("wrap_pre_pc", pc_out, 32'h400);
    tick(); branch_on(32'hFFFF_FFFF);
    tick(); br_en = 1'b0;
    wait_sig(1, 1'b1, "wrap_word");
    chk("wrap_top_pc", pc_out, 32'hFFFF_FFFC);
    lat_max = 5;
    wait_sig(0, 1'b1, "wrap_req");
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_cnt", fetch_count, 32'd6);

    // Reset with a fetch outstanding, then a late ack
    tick(); Clr = 1'b1; stream_restart(RST_PC);
    tick(); Clr = 1'b0; force_ack = 1'b1;
    @(negedge Clk);
    chk("clr_req", {31'd0, mem_req}, 32'd0);
    chk("clr_addr", mem_addr, RST_PC);
    chk("clr_inst", instruction, 32'd0);
    chk("clr_valid", {31'd0, inst_valid}, 32'd0);
    chk("clr_pc", pc_out, 32'd0);
    chk("clr_cnt", fetch_count, 32'd0);
    tick(); force_ack = 1'b0;
    @(negedge Clk);
    chk("late_ack_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_ack_inst", instruction, 32'd0);
    tick();
    @(negedge Clk);
    chk("clr_reissue", {31'd0, mem_req}, 32'd1);
    chk("clr_reissue_addr", mem_addr, RST_PC);
    $display("directed scenarios done");

    // Randomized traffic
    lat_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      stall = ($urandom % 4 == 0);
      if (br_en) br_en = 1'b0;
      else if ($urandom % 20 == 0) branch_on($urandom);
    end
    tick(); br_en = 1'b0; stall = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the datapath: it owns the program counter, reads instruction words from instruction memory over a request/acknowledge handshake, and holds the current instruction in a single-entry instruction register. The datapath consumes that register through `instruction`. A one-cycle branch pulse from the control logic redirects the PC and flushes stale words. A delivered-instruction counter is provided for debug.

## Interface
Parameters
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Clr`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  instruction-memory request (registered).
- `mem_addr`  out  32  word address of the request (registered; bits [1:0] always 0).
- `mem_ack`  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  instruction word from memory.
- `br_en`  in  1  one-cycle redirect pulse.
- `br_target`  in  32  redirect address; bits [1:0] are ignored (forced to 0).
- `stall`  in  1  consumer not ready. The consumer takes the word in any cycle with `inst_valid`=1 and `stall`=0.
- `instruction`  out  32  instruction register, feeding the datapath.
- `inst_valid`  out  1  `instruction` holds an undelivered word.
- `pc_out`  out  32  address the current `instruction` was fetched from.
- `fetch_count`  out  32  number of words delivered to the consumer (wraps).

## Operation
- **Reset** (`Clr`=1 at an edge; overrides every other input):
  - state=S_INIT, pc=RESET_PC, kill=0.
  - Outputs: `mem_req`=0, `mem_addr`=RESET_PC, `instruction`=0, `inst_valid`=0, `pc_out`=0, `fetch_count`=0.
- **S_INIT**: `mem_req`=0; always → S_ISSUE.
- **S_ISSUE**: `mem_req`=0.
  - If `br_en`: pc←{br_target[31:2],2'b00}, `inst_valid`←0, stay in S_ISSUE (no issue this cycle).
  - Else, if the buffer is free at the end of the cycle (`inst_valid`=0 or `stall`=0): `mem_addr`←pc, `mem_req`←1, → S_WAIT.
  - Else stay.
- **S_WAIT**: `mem_req`=1; `mem_addr` stays stable until ack. A request is never withdrawn.
  - `br_en` (with or without ack): pc←{br_target[31:2],2'b00}, `inst_valid`←0, kill←1.
  - `mem_ack`: `mem_req`←0, → S_ISSUE.
    - If kill=1 or `br_en`=1 this cycle: the word is discarded, kill←0, and only the branch pc update applies.
    - Otherwise: `instruction`←`mem_rdata`, `pc_out`←pc, pc←pc+4 (mod 2^32; FFFF_FFFC wraps to 0000_0000), `inst_valid`←1.
- **Delivery**: a cycle with `inst_valid`=1 and `stall`=0 and no `br_en` → `inst_valid`←0, `fetch_count`←+1. A `br_en` in that cycle flushes the word instead and does not count it.
- **Buffer invariant**: `inst_valid`=0 whenever `mem_ack` arrives in S_WAIT, because issue happens only when the buffer is free. No overflow case exists.
- A second `br_en` while kill=1: pc takes the newest target; kill stays 1.
- `mem_ack` outside S_WAIT is ignored.

## Timing
- Reset → first `mem_req`=1 at cycle 2 (S_INIT at 1, S_ISSUE at 1→2).
- Fetch latency: `mem_req` rises 1 cycle after the S_ISSUE decision; `inst_valid` rises 1 cycle after `mem_ack`.
- With zero-wait memory (ack in the first `mem_req` cycle), peak throughput is one instruction per 2 cycles.
- Branch latency:
  - `br_en` in S_ISSUE at t → `mem_req` with the target at t+2.
  - `br_en` in S_WAIT → target issued 2 cycles after the pending ack.
- `instruction` and `pc_out` hold their values while `stall`=1.
- `Clr` mid-transaction abandons the outstanding request; an ack arriving after reset is ignored (state ≠ S_WAIT).

## Structure
- Shared package `fetch_pkg`:
  - state encoding S_INIT/S_ISSUE/S_WAIT (2 bits).
  - `PC_STEP`=32'd4.
  - `WORD_MASK`=32'hFFFF_FFFC.
- No sub-module. The PC, instruction register, kill flag and counter are local registers in one always block, plus combinational next-state logic.

## Test plan
- **Reset/fetch**: RESET_PC=0x100, zero-wait memory returning 0xE3A01005 → `mem_addr`=0x100 at cycle 2, `instruction`=0xE3A01005, `pc_out`=0x100, next `mem_addr`=0x104.
- **Stall**: hold `stall`=1 for 5 cycles with `inst_valid`=1 → no `mem_req`, `instruction` stable, `fetch_count` unchanged; on release, count +1 and the next request issues.
- **Wait states**: `mem_ack` 3 cycles late → `mem_addr` constant and `mem_req`=1 throughout; word captured only on ack.
- **Branch during WAIT**: `br_en`, target 0x203 → pending word discarded, next `mem_addr`=0x200, `inst_valid` stays 0 until the 0x200 word arrives.
- **Simultaneous events**: `br_en` with `mem_ack` in the same cycle → word discarded; `br_en` during delivery → word flushed, not counted.
- **Wrap and reset**: pc=0xFFFF_FFFC → next `mem_addr`=0x0; `Clr` asserted in S_WAIT → all outputs return to reset values and a late ack is ignored.
